fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end for the pipelined RV32I core.
- Owns the PC register and drives the address of the combinational instruction memory.
- Captures each returned instruction word, together with its PC, into a small in-order buffer.
- Presents buffer entries to decode through a valid/ready handshake; execute-stage redirects (branch/jump) flush the buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
DEPTH, 2, fetch buffer entries; power of two, >= 2.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  asynchronous active-low reset.
o_addr_inst  output  32  fetch address to instruction memory; equals PC register.
i_inst  input  32  instruction word returned combinationally for o_addr_inst.
i_redirect  input  1  one-cycle pulse: flush and load new PC.
i_redirect_pc  input  32  redirect target.
o_valid  output  1  head entry valid.
o_inst  output  32  head entry instruction.
o_pc  output  32  head entry PC.
i_ready  input  1  decode accepts head entry.
o_exc_misalign  output  1  head entry carries misaligned-target flag (present only with FETCH_MISALIGN_EN).

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset state: pc_q=RESET_PC; buffer count=0; rd/wr pointers=0; all entries cleared to 0; o_valid=0; o_inst=0; o_pc=0; o_exc_misalign=0.
- o_addr_inst = pc_q, combinational. The memory returns i_inst in the same cycle.
- pop = o_valid & i_ready.
- push = ~i_redirect & ((count < DEPTH) | pop).
  - On push: entry[wr] <= {pc_q, i_inst}; wr++; pc_q <= pc_q + 4.
- No push: pc_q holds and the same address is re-presented.
- Full buffer with simultaneous pop: push is still allowed, so a full buffer sustains one instruction per cycle.
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Latency: an instruction fetched at PC A in cycle n is at the buffer head no earlier than cycle n+1.
  - With an empty buffer and i_ready held high, o_valid rises one cycle after reset release and stays high.
  - Throughput is 1 instruction/cycle.
- Head outputs: o_valid = (count != 0). o_inst/o_pc = entry[rd], taken directly from registers with no combinational path from i_inst.
- Redirect (cycle n): count <= 0; rd <= 0; wr <= 0; pc_q <= i_redirect_pc; no push in cycle n.
  - A pop in cycle n counts as completed.
  - All other entries are discarded.
  - o_valid = 0 in cycle n+1.
  - The instruction at i_redirect_pc is fetched in cycle n+1 and presented in cycle n+2.
- Redirect has priority over push. Back-to-back redirects: the last one wins.
- PC arithmetic: modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- Handshake rules:
  - While o_valid=1 and i_ready=0, o_inst/o_pc/o_exc_misalign are stable until pop or redirect.
  - i_ready is ignored when o_valid=0.
- Reset mid-operation: immediate return to the reset state; buffered entries are lost.

Optional Feature:
Macro FETCH_MISALIGN_EN.
- Defined:
  - pc_q keeps all 32 bits of i_redirect_pc.
  - A redirect target with bits[1:0] != 0 sets a sticky mis_q. While mis_q=1:
    - fetch stops (push = 0);
    - a single entry {pc_q, 32'h0000_0013, misalign=1} is pushed once, with a NOP payload.
  - o_exc_misalign reflects the head entry's flag.
  - mis_q clears on the next redirect or on reset.
- Undefined:
  - The o_exc_misalign port is absent.
  - pc_q <= {i_redirect_pc[31:2], 2'b00}; the low bits are silently dropped.

Test Plan:
1. Reset release, RESET_PC=0, memory words 0..3 = 0x11,0x22,0x33,0x44, i_ready=1:
   - o_addr_inst = 0,4,8,...;
   - o_valid rises at cycle 1;
   - o_pc/o_inst = 0/0x11, 4/0x22, 8/0x33, one per cycle.
2. Backpressure: i_ready=0 for 5 cycles after the first entry, DEPTH=2:
   - count reaches 2 and pc_q freezes at 8;
   - head stays 0/0x11;
   - on i_ready=1 the sequence continues 0,4,8,... with nothing lost or duplicated.
3. Redirect to 0x100 while full and i_ready=1:
   - the head pop completes;
   - o_valid=0 next cycle;
   - o_pc=0x100 two cycles after the redirect;
   - no stale PC 4/8 appears.
4. Wrap: redirect to 32'hFFFF_FFF8:
   - o_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
5. Asynchronous reset asserted mid-stream between clock edges:
   - o_valid=0 and o_addr_inst=RESET_PC immediately, without waiting for a clock edge.
6. FETCH_MISALIGN_EN: redirect to 0x102:
   - single entry o_pc=0x102, o_inst=0x13, o_exc_misalign=1, then o_valid=0 persists;
   - redirect to 0x200 resumes normal fetch with o_exc_misalign=0.
   - Without the macro, the same stimulus gives o_pc=0x100.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, redirect input and decode handshake.
// With FETCH_MISALIGN_EN defined, carries the o_exc_misalign head flag.
interface fetch_stage_if;
   logic [31:0] o_addr_inst;
   logic [31:0] i_inst;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_valid;
   logic [31:0] o_inst;
   logic [31:0] o_pc;
   logic        i_ready;
`ifdef FETCH_MISALIGN_EN
   logic        o_exc_misalign;
`endif

   // Fetch stage side
   modport master (
`ifdef FETCH_MISALIGN_EN
      output o_exc_misalign,
`endif
      output o_addr_inst,
      output o_valid,
      output o_inst,
      output o_pc,
      input  i_inst,
      input  i_redirect,
      input  i_redirect_pc,
      input  i_ready
   );

   // Memory / execute / decode side
   modport slave (
`ifdef FETCH_MISALIGN_EN
      input  o_exc_misalign,
`endif
      input  o_addr_inst,
      input  o_valid,
      input  o_inst,
      input  o_pc,
      output i_inst,
      output i_redirect,
      output i_redirect_pc,
      output i_ready
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, combinational imem address and an
// in-order {pc, inst} buffer drained by decode over valid/ready.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned redirect targets produce
// one flagged NOP entry and stop fetch until the next redirect).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input logic           i_clk,
   input logic           i_rst_n,
   fetch_stage_if.master bus
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   pc_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [31:0]   ent_inst_q [DEPTH];
   logic [31:0]   ent_pc_q   [DEPTH];

   logic          valid;
   logic          pop;
   logic          push;
   logic [31:0]   push_inst;
   logic          push_mis;
   logic          advance_pc;
   logic [31:0]   redirect_target;

`ifdef FETCH_MISALIGN_EN
   logic          ent_mis_q [DEPTH];
   logic          mis_q;
   logic          mis_done_q;
`endif

   // Push/pop decision and the payload written on push
   always_comb begin
      valid = (count_q != '0);
      pop   = valid & bus.i_ready;
`ifdef FETCH_MISALIGN_EN
      push            = ~bus.i_redirect & ~(mis_q & mis_done_q) & ((count_q < DEPTH_C) | pop);
      push_inst       = mis_q ? NOP : bus.i_inst;
      push_mis        = mis_q;
      advance_pc      = ~mis_q;
      redirect_target = bus.i_redirect_pc;
`else
      push            = ~bus.i_redirect & ((count_q < DEPTH_C) | pop);
      push_inst       = bus.i_inst;
      push_mis        = 1'b0;
      advance_pc      = 1'b1;
      redirect_target = {bus.i_redirect_pc[31:2], 2'b00};
`endif
   end

   // PC, pointers, count and buffer storage; redirect overrides any push
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q    <= RESET_PC;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_inst_q[i] <= '0;
            ent_pc_q[i]   <= '0;
         end
      end else if (bus.i_redirect) begin
         pc_q    <= redirect_target;
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         if (push) begin
            ent_inst_q[wr_q] <= push_inst;
            ent_pc_q[wr_q]   <= pc_q;
            wr_q             <= wr_q + PW'(1);
            if (advance_pc) pc_q <= pc_q + 32'd4;
         end
         if (pop) rd_q <= rd_q + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

`ifdef FETCH_MISALIGN_EN
   // Sticky misalign state; the flagged NOP goes out exactly once per bad target
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mis_q      <= 1'b0;
         mis_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) ent_mis_q[i] <= 1'b0;
      end else if (bus.i_redirect) begin
         mis_q      <= (bus.i_redirect_pc[1:0] != 2'b00);
         mis_done_q <= 1'b0;
      end else if (push) begin
         ent_mis_q[wr_q] <= push_mis;
         if (mis_q) mis_done_q <= 1'b1;
      end
   end

   assign bus.o_exc_misalign = ent_mis_q[rd_q];
`else
   logic unused_push_mis;
   assign unused_push_mis = push_mis;
`endif

   assign bus.o_addr_inst = pc_q;
   assign bus.o_valid     = valid;
   assign bus.o_inst      = ent_inst_q[rd_q];
   assign bus.o_pc        = ent_pc_q[rd_q];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random
// ready/redirect traffic, compared each cycle against a queue-based model.
module tb_fetch_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 2;

   logic clk;
   logic rst_n;
   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: known words at 0..12, a scrambled value elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h11;
         32'h4:   return 32'h22;
         32'h8:   return 32'h33;
         32'hC:   return 32'h44;
         default: return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
      endcase
   endfunction

   assign bus.i_inst = mem_word(bus.o_addr_inst);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the decode-visible queue and the next fetch address
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc;
   logic        m_mis;
   logic        m_mis_done;

   task automatic model_reset();
      q.delete();
      m_pc       = RESET_PC;
      m_mis      = 1'b0;
      m_mis_done = 1'b0;
   endtask

   task automatic model_step(input logic rdy, input logic redir, input logic [31:0] tgt);
      bit   pop;
      bit   push;
      ent_t e;
      pop  = (q.size() != 0) && rdy;
      push = !redir && ((q.size() < DEPTH) || pop) && !(m_mis && m_mis_done);
      if (pop) void'(q.pop_front());
      if (redir) begin
         q.delete();
`ifdef FETCH_MISALIGN_EN
         m_pc       = tgt;
         m_mis      = (tgt[1:0] != 2'b00);
         m_mis_done = 1'b0;
`else
         m_pc = {tgt[31:2], 2'b00};
`endif
      end else if (push) begin
         e.pc   = m_pc;
         e.inst = m_mis ? 32'h13 : mem_word(m_pc);
         e.mis  = m_mis;
         q.push_back(e);
         if (m_mis) m_mis_done = 1'b1;
         else       m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic compare_all();
      check("valid", {31'b0, bus.o_valid}, {31'b0, q.size() != 0});
      check("addr", bus.o_addr_inst, m_pc);
      if (q.size() != 0) begin
         check("head_pc", bus.o_pc, q[0].pc);
         check("head_inst", bus.o_inst, q[0].inst);
`ifdef FETCH_MISALIGN_EN
         check("head_mis", {31'b0, bus.o_exc_misalign}, {31'b0, q[0].mis});
`endif
      end
   endtask

   // One cycle: compare at the falling edge, then drive inputs for the next rising edge
   task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
      @(negedge clk);
      compare_all();
      bus.i_ready       = rdy;
      bus.i_redirect    = redir;
      bus.i_redirect_pc = tgt;
      model_step(rdy, redir, tgt);
   endtask

   task automatic release_reset(input logic rdy);
      @(negedge clk);
      model_reset();
      bus.i_ready    = rdy;
      bus.i_redirect = 1'b0;
      rst_n          = 1'b1;
      model_step(rdy, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] t;
      rst_n             = 1'b0;
      bus.i_ready       = 1'b1;
      bus.i_redirect    = 1'b0;
      bus.i_redirect_pc = 32'h0;
      model_reset();
      #3;
      check("rst_valid", {31'b0, bus.o_valid}, 32'h0);
      check("rst_pc", bus.o_pc, 32'h0);
      check("rst_inst", bus.o_inst, 32'h0);
      check("rst_addr", bus.o_addr_inst, RESET_PC);
      repeat (2) @(negedge clk);

      // Streaming from reset with decode always ready
      release_reset(1'b1);
      step(1'b1, 1'b0, 32'h0);
      check("t1_valid_c1", {31'b0, bus.o_valid}, 32'h1);
      check("t1_pc_c1", bus.o_pc, 32'h0);
      check("t1_inst_c1", bus.o_inst, 32'h11);
      step(1'b1, 1'b0, 32'h0);
      check("t1_pc_c2", bus.o_pc, 32'h4);
      check("t1_inst_c2", bus.o_inst, 32'h22);
      step(1'b1, 1'b0, 32'h0);
      check("t1_pc_c3", bus.o_pc, 32'h8);
      check("t1_inst_c3", bus.o_inst, 32'h33);

      // Asynchronous reset between edges
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'b0, bus.o_valid}, 32'h0);
      check("arst_addr", bus.o_addr_inst, RESET_PC);
      model_reset();

      // Backpressure after the first entry
      release_reset(1'b0);
      repeat (5) step(1'b0, 1'b0, 32'h0);
      check("t2_addr_frozen", bus.o_addr_inst, 32'h8);
      check("t2_head_pc", bus.o_pc, 32'h0);
      check("t2_head_inst", bus.o_inst, 32'h11);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check("t2_resume_pc", bus.o_pc, 32'h4);

      // Redirect while full and ready
      step(1'b1, 1'b1, 32'h100);
      step(1'b1, 1'b0, 32'h0);
      check("t3_valid_gap", {31'b0, bus.o_valid}, 32'h0);
      check("t3_addr", bus.o_addr_inst, 32'h100);
      step(1'b1, 1'b0, 32'h0);
      check("t3_pc", bus.o_pc, 32'h100);
      step(1'b1, 1'b0, 32'h0);
      check("t3_pc_next", bus.o_pc, 32'h104);

      // PC wrap-around
      step(1'b1, 1'b1, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check("t4_pc0", bus.o_pc, 32'hFFFF_FFF8);
      step(1'b1, 1'b0, 32'h0);
      check("t4_pc1", bus.o_pc, 32'hFFFF_FFFC);
      step(1'b1, 1'b0, 32'h0);
      check("t4_pc2", bus.o_pc, 32'h0000_0000);
      check("t4_inst2", bus.o_inst, 32'h11);
      step(1'b1, 1'b0, 32'h0);
      check("t4_pc3", bus.o_pc, 32'h0000_0004);

      // Misaligned redirect target
      step(1'b1, 1'b1, 32'h102);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_EN
      check("t6_pc", bus.o_pc, 32'h102);
      check("t6_inst", bus.o_inst, 32'h13);
      check("t6_mis", {31'b0, bus.o_exc_misalign}, 32'h1);
      repeat (3) step(1'b1, 1'b0, 32'h0);
      check("t6_stalled", {31'b0, bus.o_valid}, 32'h0);
      step(1'b1, 1'b1, 32'h200);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      check("t6_resume_pc", bus.o_pc, 32'h200);
      check("t6_resume_mis", {31'b0, bus.o_exc_misalign}, 32'h0);
`else
      check("t6_pc", bus.o_pc, 32'h100);
      check("t6_inst", bus.o_inst, mem_word(32'h100));
`endif

      // Random ready/redirect traffic
      for (int i = 0; i < 600; i++) begin
         logic rdy;
         logic redir;
         rdy   = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 15) == 0);
         t     = $urandom;
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         step(rdy, redir, t);
      end
      @(negedge clk);
      compare_all();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
